// File: rtl/dcache_pkg.sv
// Shared types and field layout for the write-back data cache.
// Optional counters: define DCACHE_STATS_EN.
package dcache_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int OFF_W  = 2;
  localparam int WORDS  = LINE_W / WORD_W;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_IDX_W  = 3;
  localparam int IDX_LSB    = OFF_W;

  localparam logic [1:0] ST_COMPARE   = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;

  function automatic int tag_w(input int addr_w, input int idx_w);
    return addr_w - OFF_W - idx_w;
  endfunction

  localparam int DEF_TAG_W = tag_w(DEF_ADDR_W, DEF_IDX_W);

endpackage

// File: rtl/dcache_line_store.sv
// Line data, tags and valid/dirty state for the data cache.
// Combinational read port, full-line fill port, word store port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [LINE_W-1:0] rd_line,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [LINE_W-1:0] fill_line,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic              word_en,
  input  logic [IDX_W-1:0]  word_idx,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [WORD_W-1:0] word_data
);

  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_line  = data_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
    end else if (word_en) begin
      dirty_q[word_idx] <= 1'b1;
    end
  end

  // Payload arrays are not reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[fill_idx] <= fill_line;
      tag_q[fill_idx]  <= fill_tag;
    end else if (word_en) begin
      data_q[word_idx][int'(word_off)*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back write-allocate L1 data cache.
// Define DCACHE_STATS_EN to add hit_cnt/miss_cnt outputs.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int ADDR_W    = 30,
  parameter int IDX_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    proc_read,
  input  logic                    proc_write,
  input  logic [ADDR_W-1:0]       proc_addr,
  input  logic [WORD_W-1:0]       proc_wdata,
  output logic [WORD_W-1:0]       proc_rdata,
  output logic                    proc_stall,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [LINE_W-1:0]       mem_wdata,
  input  logic [LINE_W-1:0]       mem_rdata,
  input  logic                    mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]             hit_cnt,
  output logic [15:0]             miss_cnt
`endif
);

  localparam int TAG_W = tag_w(ADDR_W, IDX_W);

  logic [1:0]        state;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [LINE_W-1:0] rd_line;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              rd_dirty;
  logic              req;
  logic              hit;
  logic              fill_en;
  logic              word_en;

  assign req_tag = proc_addr[ADDR_W-1 -: TAG_W];
  assign idx     = proc_addr[IDX_LSB +: IDX_W];
  assign off     = proc_addr[OFF_W-1:0];

  assign req        = proc_read | proc_write;
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign proc_stall = !rst && req && ((state != ST_COMPARE) || !hit);
  assign proc_rdata = rd_line[int'(off)*WORD_W +: WORD_W];

  assign fill_en = (state == ST_ALLOCATE) && mem_ready;
  assign word_en = proc_write && (state == ST_COMPARE) && hit;

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (idx),
    .rd_line   (rd_line),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .fill_en   (fill_en),
    .fill_idx  (idx),
    .fill_line (mem_rdata),
    .fill_tag  (req_tag),
    .word_en   (word_en),
    .word_idx  (idx),
    .word_off  (off),
    .word_data (proc_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_COMPARE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_COMPARE: begin
          if (req && !hit) begin
            if (rd_valid && rd_dirty) begin
              state     <= ST_WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {rd_tag, idx};
              mem_wdata <= rd_line;
            end else begin
              state    <= ST_ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= {req_tag, idx};
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready) begin
            state     <= ST_ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {req_tag, idx};
          end
        end
        ST_ALLOCATE: begin
          if (mem_ready) begin
            state    <= ST_COMPARE;
            mem_read <= 1'b0;
          end
        end
        default: state <= ST_COMPARE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (req && !proc_stall && (hit_cnt != 16'hFFFF))
        hit_cnt <= hit_cnt + 16'd1;
      if ((state == ST_COMPARE) && req && !hit && (miss_cnt != 16'hFFFF))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: directed loads/stores against a
// latency-5 line memory model.
module tb_dcache_wb;

  localparam int LAT = 5;

  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  logic         clk;
  logic         rst;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_STATS_EN
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;
`endif

  int checks = 0;
  int passes = 0;
  logic overlap = 1'b0;
  logic [31:0] exp_rd[$];
  mem_exp_t    exp_mem[$];
  logic [127:0] memq [logic [27:0]];

  dcache_wb dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] line_of(input logic [27:0] a);
    logic [127:0] l;
    if (memq.exists(a)) return memq[a];
    for (int w = 0; w < 4; w++) begin
      if (a == 28'h4) l[w*32 +: 32] = 32'(w + 1);
      else l[w*32 +: 32] = {a[23:0], 8'(w + 1)};
    end
    return l;
  endfunction

  function automatic mem_exp_t mx(input logic wr, input logic [27:0] a,
                                  input logic [127:0] d);
    mem_exp_t e;
    e.wr = wr;
    e.addr = a;
    e.wdata = d;
    return e;
  endfunction

  // Slow memory: ready pulses on the LAT-th cycle of a request.
  initial begin
    int busy = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!rst && (mem_read || mem_write)) begin
        busy++;
        if (busy == LAT) begin
          busy = 0;
          mem_ready = 1'b1;
          if (mem_write) memq[mem_addr] = mem_wdata;
          else mem_rdata = line_of(mem_addr);
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Monitor: pops expectations when the DUT presents load data or
  // starts a memory transaction.
  initial begin
    logic prev_r = 1'b0;
    logic prev_w = 1'b0;
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) overlap = 1'b1;
      if (!rst && proc_read && !proc_write && !proc_stall) begin
        if (exp_rd.size() == 0) check("unexpected_load", 1, 0);
        else check("load_data", proc_rdata, exp_rd.pop_front());
      end
      if ((mem_read && !prev_r) || (mem_write && !prev_w)) begin
        if (exp_mem.size() == 0) begin
          check("unexpected_mem_req", {mem_write, mem_addr}, 0);
        end else begin
          e = exp_mem.pop_front();
          check("mem_is_write", mem_write, e.wr);
          check("mem_addr", mem_addr, e.addr);
          if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      prev_r = mem_read;
      prev_w = mem_write;
    end
  end

  task automatic access(input logic wr, input logic [29:0] a,
                        input logic [31:0] d, input int stalls);
    int n = 0;
    proc_addr = a;
    proc_wdata = d;
    proc_write = wr;
    proc_read = !wr;
    if (!wr) exp_rd.push_back(d);
    forever begin
      @(negedge clk);
      if (!proc_stall) break;
      n++;
      if (n > 200) begin
        check("stall_timeout", n, stalls);
        break;
      end
      @(posedge clk);
      #1;
    end
    check("stall_cycles", n, stalls);
    @(posedge clk);
    #1;
    proc_read = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    proc_read = 1'b1;
    proc_write = 1'b0;
    proc_addr = 30'h10;
    proc_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", proc_stall, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
`ifdef DCACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    proc_read = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss, then hits and a store hit
    exp_mem.push_back(mx(1'b0, 28'h4, '0));
    access(1'b0, 30'h10, 32'h1, 6);
    access(1'b0, 30'h11, 32'h2, 0);
    access(1'b1, 30'h12, 32'hDEAD_BEEF, 0);
    access(1'b0, 30'h12, 32'hDEAD_BEEF, 0);

    // Dirty conflict: writeback then fill
    exp_mem.push_back(mx(1'b1, 28'h4,
      {32'h4, 32'hDEAD_BEEF, 32'h2, 32'h1}));
    exp_mem.push_back(mx(1'b0, 28'h24, '0));
    access(1'b0, 30'h90, 32'h2401, 11);

    // Clean conflict: fill only, data comes back from written line
    exp_mem.push_back(mx(1'b0, 28'h4, '0));
    access(1'b0, 30'h13, 32'h4, 6);
    access(1'b0, 30'h12, 32'hDEAD_BEEF, 0);

    // Last index
    exp_mem.push_back(mx(1'b0, 28'h7, '0));
    access(1'b0, 30'h1D, 32'h702, 6);
    access(1'b1, 30'h1F, 32'hCAFE_F00D, 0);
    exp_mem.push_back(mx(1'b1, 28'h7,
      {32'hCAFE_F00D, 32'h703, 32'h702, 32'h701}));
    exp_mem.push_back(mx(1'b0, 28'hF, '0));
    access(1'b0, 30'h3C, 32'hF01, 11);

    // Reset in the middle of a fill
    exp_mem.push_back(mx(1'b0, 28'hC, '0));
    proc_addr = 30'h30;
    proc_read = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("alloc_before_rst", mem_read, 1);
    rst = 1'b1;
    proc_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mem_read_after_rst", mem_read, 0);
`ifdef DCACHE_STATS_EN
    check("hit_cnt_cleared", hit_cnt, 0);
    check("miss_cnt_cleared", miss_cnt, 0);
`endif
    @(posedge clk);
    #1;
    exp_mem.push_back(mx(1'b0, 28'h4, '0));
    access(1'b0, 30'h10, 32'h1, 6);
`ifdef DCACHE_STATS_EN
    check("hit_cnt_one", hit_cnt, 1);
    check("miss_cnt_one", miss_cnt, 1);
`endif

    repeat (3) @(posedge clk);
    check("load_queue_drained", exp_rd.size(), 0);
    check("mem_queue_drained", exp_mem.size(), 0);
    check("rd_wr_overlap", overlap, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
